// File: rtl/clk_mon_pkg.sv
// Shared types and default sizing for the clock-frequency monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned TIMEOUT_DEF     = 1024;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_mon_sync_edge.sv
// Synchronizes a slow monitored clock into i_clk and flags its rising edges.
// Latency: o_level follows i_async after STAGES edges; o_rise is combinational on top.
// Backpressure: none; free-running sampler.
//
// Ports:
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_async      : asynchronous input level
//   o_level      : synchronized level
//   o_rise       : high for one cycle when o_level goes 0 -> 1
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  assign sync_d = {sync_q[STAGES-2:0], i_async};
  assign hist_d = sync_q[STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign o_level = sync_q[STAGES-1];
  assign o_rise  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_mon.sv
// Measures period and high time of a slow monitored clock, flags period errors and stuck clocks.
// Latency: o_period/o_high/o_valid/o_err update one cycle after the closing synchronized rise.
// Backpressure: none; o_valid is a one-cycle pulse with no ready.
//
// Ports:
//   i_clk, i_rst             : system clock, synchronous active-high reset
//   i_en                     : measurement enable (low forces IDLE)
//   i_clr                    : clears sticky o_err
//   i_mon                    : monitored clock (<= f(i_clk)/4)
//   i_exp_period, i_tol      : expected period and allowed absolute deviation
//   o_period, o_high, o_valid: last measurement and its update strobe
//   o_err, o_stuck           : sticky period mismatch, no-rise timeout
module clk_mon
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_mon,
  input  logic [CNT_W-1:0] i_exp_period,
  input  logic [CNT_W-1:0] i_tol,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_err,
  output logic             o_stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  logic level, rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_mon),
    .o_level (level),
    .o_rise  (rise)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, err_q, err_d, stuck_q, stuck_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic [CNT_W:0]   diff, absdiff;
  logic             mismatch;

  assign cnt_inc     = sat_inc(cnt_q);
  assign timeout_hit = (cnt_inc == TO_VAL);

  // One extra bit keeps the sign of cnt - expected.
  always_comb begin
    diff     = {1'b0, cnt_q} - {1'b0, i_exp_period};
    absdiff  = diff[CNT_W] ? ((~diff) + {{CNT_W{1'b0}}, 1'b1}) : diff;
    mismatch = (absdiff > {1'b0, i_tol});
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A timeout in MEASURE drops back to SYNC so the stuck
  // interval is never reported as a period; the next rise restarts cleanly.
  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (rise) state_d = MEASURE;
        MEASURE: if (!rise && timeout_hit) state_d = SYNC;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    err_d    = i_clr ? 1'b0 : err_q;
    if (!i_en) begin
      cnt_d   = '0;
      hcnt_d  = '0;
      stuck_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          stuck_d = 1'b0;
        end
        SYNC: begin
          if (rise) begin
            cnt_d   = ONE;
            hcnt_d  = ONE;
            stuck_d = 1'b0;
          end else begin
            cnt_d  = cnt_inc;
            hcnt_d = '0;
            if (timeout_hit) stuck_d = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            cnt_d    = ONE;
            hcnt_d   = ONE;
            stuck_d  = 1'b0;
            if (mismatch) err_d = 1'b1;  // a new error beats i_clr
          end else begin
            cnt_d = cnt_inc;
            if (level) hcnt_d = sat_inc(hcnt_q);
            if (timeout_hit) stuck_d = 1'b1;
          end
        end
        default: begin
          cnt_d  = '0;
          hcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      stuck_q  <= stuck_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_stuck  = stuck_q;

endmodule

// File: tb/tb_clk_mon.sv
module tb_clk_mon;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          i_clk = 1'b0;
  logic          i_rst, i_en, i_clr, i_mon;
  logic [CW-1:0] i_exp_period, i_tol, o_period, o_high;
  logic          o_valid, o_err, o_stuck;

  clk_mon #(.CNT_W(CW), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_clr        (i_clr),
    .i_mon        (i_mon),
    .i_exp_period (i_exp_period),
    .i_tol        (i_tol),
    .o_period     (o_period),
    .o_high       (o_high),
    .o_valid      (o_valid),
    .o_err        (o_err),
    .o_stuck      (o_stuck)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int p;
    int h;
    bit b;  // this period is out of tolerance
    bit e;  // expected o_err when its o_valid shows
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   cur_exp, cur_tol;
  bit   err_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // One clock; outputs sampled 1 time unit after the edge. Every o_valid is
  // matched against the oldest expected measurement.
  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("period", o_period, e.p);
        chk("high", o_high, e.h);
        chk("err_at_valid", o_err, e.e);
      end
    end
  endtask

  task automatic set_cfg(input int ex, input int tol);
    cur_exp      = ex;
    cur_tol      = tol;
    i_exp_period = CW'(ex);
    i_tol        = CW'(tol);
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    tick();
    i_clr   = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic begin_run();
    i_mon = 1'b0;
    i_en  = 1'b1;
    repeat (5) tick();
  endtask

  // One monitored period: high h cycles then low p-h cycles.
  task automatic seg(input int p, input int h, input bit meas);
    if (meas) begin
      exp_t e;
      e.p = p;
      e.h = h;
      e.b = (iabs(p - cur_exp) > cur_tol);
      if (e.b) err_exp = 1'b1;
      e.e = err_exp;
      sb_q.push_back(e);
    end
    i_mon = 1'b1;
    repeat (h) tick();
    i_mon = 1'b0;
    repeat (p - h) tick();
  endtask

  // Closing rise for the last period; optionally land i_clr on its update cycle.
  task automatic end_run(input bit clr_at_upd);
    i_mon = 1'b1;
    tick();
    tick();
    if (clr_at_upd) begin
      exp_t t;
      t = sb_q.pop_back();
      t.e = t.b;
      err_exp = t.b;
      sb_q.push_back(t);
      i_clr = 1'b1;
    end
    tick();
    i_clr = 1'b0;
    tick();
    i_mon = 1'b0;
    i_en  = 1'b0;
    repeat (3) tick();
    chk("all_valids_seen", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j, p, h;
    i_rst = 1'b1; i_en = 1'b0; i_clr = 1'b0; i_mon = 1'b0;
    err_exp = 1'b0;
    set_cfg(4, 0);

    // Reset state
    repeat (3) tick();
    chk("rst_period", o_period, 0);
    chk("rst_high", o_high, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_stuck", o_stuck, 0);
    i_rst = 1'b0;
    tick();

    // Divide-by-4, 50% duty, exact match
    begin_run();
    repeat (6) seg(4, 2, 1'b1);
    end_run(1'b0);
    chk("div4_err", o_err, 0);

    // Abort mid-period by dropping i_en: no report, old period held
    begin_run();
    i_mon = 1'b1; tick(); tick();
    i_mon = 1'b0; tick(); tick();
    i_en = 1'b0;
    repeat (4) tick();
    chk("abort_period_hold", o_period, 4);
    chk("abort_high_hold", o_high, 2);
    chk("abort_valid_low", o_valid, 0);
    begin_run();
    repeat (2) seg(6, 3, 1'b1);
    end_run(1'b0);

    // Period 5 against 4, tol 0: sticky error, clear, re-set on next bad period
    begin_run();
    repeat (3) seg(5, 2, 1'b1);
    end_run(1'b0);
    chk("err_sticky", o_err, 1);
    pulse_clr();
    chk("err_cleared", o_err, 0);
    begin_run();
    seg(4, 2, 1'b1);
    seg(5, 2, 1'b1);
    end_run(1'b0);
    chk("err_reset_by_bad", o_err, 1);

    // Same input within tolerance 1
    set_cfg(4, 1);
    pulse_clr();
    begin_run();
    repeat (3) seg(5, 2, 1'b1);
    seg(4, 2, 1'b1);
    end_run(1'b0);
    chk("tol1_no_err", o_err, 0);

    // i_clr coinciding with a new error: the set wins
    set_cfg(4, 0);
    begin_run();
    seg(4, 2, 1'b1);
    seg(6, 3, 1'b1);
    end_run(1'b1);
    chk("set_beats_clr", o_err, 1);
    pulse_clr();

    // Stuck clock: timeout TO cycles after the last rise, cleared by next rise
    begin_run();
    repeat (2) seg(4, 2, 1'b1);
    i_mon = 1'b1;
    k = cyc;            // rise shows up at k+2
    tick(); tick();
    i_mon = 1'b0;
    while (cyc < k + 2 + TO - 1) tick();
    chk("stuck_before_timeout", o_stuck, 0);
    tick();
    chk("stuck_at_timeout", o_stuck, 1);
    repeat (10) tick();
    chk("stuck_held", o_stuck, 1);
    begin
      exp_t e;
      e.p = 4; e.h = 2; e.b = 1'b0; e.e = err_exp;
      sb_q.push_back(e);
    end
    i_mon = 1'b1;
    j = cyc;
    tick(); tick();
    chk("stuck_until_rise", o_stuck, 1);
    i_mon = 1'b0;
    tick();
    chk("stuck_clear_on_rise", o_stuck, 0);
    tick();
    if (cyc != j + 4) chk("stuck_restart_timing", cyc, j + 4);
    seg(4, 2, 1'b1);
    end_run(1'b0);
    chk("stuck_idle_low", o_stuck, 0);

    // Randomized periods and duty cycles against random expectations
    for (int r = 0; r < 6; r++) begin
      set_cfg($urandom_range(12, 4), $urandom_range(2, 0));
      pulse_clr();
      begin_run();
      for (int s = 0; s < 8; s++) begin
        p = $urandom_range(12, 4);
        h = $urandom_range(p - 1, 1);
        seg(p, h, 1'b1);
      end
      end_run(1'b0);
      chk("rand_err_final", o_err, err_exp);
    end

    // Reset in the middle of a measurement with the error flag set
    set_cfg(4, 0);
    begin_run();
    seg(7, 3, 1'b1);
    seg(4, 2, 1'b1);
    i_mon = 1'b1;
    tick(); tick(); tick();
    i_rst = 1'b1;
    tick();
    chk("mrst_period", o_period, 0);
    chk("mrst_high", o_high, 0);
    chk("mrst_valid", o_valid, 0);
    chk("mrst_err", o_err, 0);
    chk("mrst_stuck", o_stuck, 0);
    sb_q.delete();
    i_rst = 1'b0;
    i_en  = 1'b0;
    i_mon = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
